// File: rtl/two_of_five_pkg.sv
`default_nettype none
// ============================================================================
// Module      : two_of_five_pkg
// Description : Shared constants for the 2-of-5 display scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package two_of_five_pkg;

    localparam int                CODE_W     = 5;
    localparam logic [CODE_W-1:0] CODE_BLANK = 5'b00000;

    localparam logic [1:0] c_st_blank = 2'd0;
    localparam logic [1:0] c_st_scan  = 2'd1;
    localparam logic [1:0] c_st_guard = 2'd2;

    // Valid codes for digits 9 down to 0, E1 in bit 0
    localparam logic [9:0][CODE_W-1:0] c_digit_codes = {
        5'b10100, 5'b10010, 5'b10001, 5'b01100, 5'b01010,
        5'b01001, 5'b00110, 5'b00101, 5'b00011, 5'b11000
    };

endpackage
`default_nettype wire

// File: rtl/two_of_five_check.sv
`default_nettype none
// ============================================================================
// Module      : two_of_five_check
// Description : Combinational validator, code is legal when exactly two bits are set.
// Revision    : 1.0 - initial release
// ============================================================================
module two_of_five_check
    import two_of_five_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    output logic              o_valid
);

    assign o_valid = ($countones(i_code) == 2);

endmodule
`default_nettype wire

// File: rtl/two_of_five_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : two_of_five_display_scanner
// Description : Multiplexed scan controller for 2-of-5 coded 7-segment digits.
//               Define INVALID_BLANK_EN to keep invalid slots dark.
// Revision    : 1.0 - initial release
// ============================================================================
module two_of_five_display_scanner
    import two_of_five_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 16
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         load_valid,
    input  logic [CODE_W*NUM_DIGITS-1:0] load_data,
    output logic                         load_ready,
    output logic [CODE_W-1:0]            code_out,
    output logic [NUM_DIGITS-1:0]        digit_n,
    output logic                         code_err,
    output logic                         err_any,
    output logic                         frame_done
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] c_ref_last = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] c_grd_last = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_DIGITS - 1);

    logic [1:0]                             r_state;
    logic [CNT_W-1:0]                       r_cnt;
    logic [IDX_W-1:0]                       r_idx;
    logic [NUM_DIGITS-1:0][CODE_W-1:0]      r_disp;
    logic [NUM_DIGITS-1:0][CODE_W-1:0]      r_pend;
    logic                                   r_pend_full;
    logic                                   r_valid;
    logic                                   r_load_ready;
    logic [CODE_W-1:0]                      r_code_out;
    logic [NUM_DIGITS-1:0]                  r_digit_n;
    logic                                   r_code_err;
    logic                                   r_err_any;
    logic                                   r_frame_done;

    logic [1:0]                             w_state_nxt;
    logic [CNT_W-1:0]                       w_cnt_nxt;
    logic [IDX_W-1:0]                       w_idx_nxt;
    logic                                   w_commit;
    logic                                   w_wrap;
    logic                                   w_take;
    logic                                   w_pend_full_nxt;
    logic [NUM_DIGITS-1:0][CODE_W-1:0]      w_disp_nxt;
    logic [CODE_W-1:0]                      w_slot_code;
    logic                                   w_slot_ok;
    logic [NUM_DIGITS-1:0]                  w_pend_ok;
    logic                                   w_scan_nxt;
    logic                                   w_lit;

    assign w_take = load_valid && r_load_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_commit    = 1'b0;
        w_wrap      = 1'b0;
        if (!enable) begin
            w_state_nxt = c_st_blank;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                c_st_blank: begin
                    // A pending frame wins; otherwise resume the last committed one
                    if (r_pend_full || r_valid) begin
                        w_commit    = r_pend_full;
                        w_state_nxt = c_st_scan;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                    end
                end
                c_st_scan: begin
                    if (r_cnt == c_ref_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_st_guard;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                c_st_guard: begin
                    if (r_cnt == c_grd_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_st_scan;
                        if (r_idx == c_idx_last) begin
                            w_idx_nxt = '0;
                            w_wrap    = 1'b1;
                            w_commit  = r_pend_full;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = c_st_blank;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // Take and commit are mutually exclusive: take needs the pending reg empty
    assign w_pend_full_nxt = w_take ? 1'b1 : (w_commit ? 1'b0 : r_pend_full);
    assign w_disp_nxt      = w_commit ? r_pend : r_disp;
    assign w_slot_code     = w_disp_nxt[w_idx_nxt];
    assign w_scan_nxt      = (w_state_nxt == c_st_scan);

    two_of_five_check u_slot_chk (
        .i_code  (w_slot_code),
        .o_valid (w_slot_ok)
    );

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_chk
        two_of_five_check u_chk (
            .i_code  (r_pend[gi]),
            .o_valid (w_pend_ok[gi])
        );
    end

`ifdef INVALID_BLANK_EN
    assign w_lit = w_scan_nxt && w_slot_ok;
`else
    assign w_lit = w_scan_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_st_blank;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_disp       <= '0;
            r_pend       <= '0;
            r_pend_full  <= 1'b0;
            r_valid      <= 1'b0;
            r_load_ready <= 1'b1;
            r_code_out   <= CODE_BLANK;
            r_digit_n    <= '1;
            r_code_err   <= 1'b0;
            r_err_any    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_pend_full  <= w_pend_full_nxt;
            r_load_ready <= !w_pend_full_nxt;
            if (w_take) begin
                r_pend <= load_data;
            end
            if (w_commit) begin
                r_disp    <= r_pend;
                r_valid   <= 1'b1;
                r_err_any <= ~&w_pend_ok;
            end
            // Outputs are computed from next-state values so pins track the state edge
            r_code_out   <= w_lit ? w_slot_code : CODE_BLANK;
            r_digit_n    <= w_lit ? ~(NUM_DIGITS'(1) << w_idx_nxt) : '1;
            r_code_err   <= w_scan_nxt && !w_slot_ok;
            r_frame_done <= w_wrap;
        end
    end

    assign load_ready = r_load_ready;
    assign code_out   = r_code_out;
    assign digit_n    = r_digit_n;
    assign code_err   = r_code_err;
    assign err_any    = r_err_any;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
